// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer
// IFU-side instruction fetch buffer. On a start pulse it streams a programmed
// number of 64-bit words from instruction memory into a local FIFO, limiting
// requests so the FIFO can never overflow, and answers IDU read requests
// with one-cycle latency.
//
// Optional build feature: define IFU_FETCH_ERR_CHK_EN to enable the sticky
// protocol-error flag fetch_err (spurious memory response, or start pulse
// while busy). Without it fetch_err is tied low.

module ifu_fetch_buffer #(
  parameter int FIFO_IFU_WIDTH = 64,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_start,
  input  logic [ADDR_WIDTH-1:0]     fetch_base_addr,
  input  logic [CNT_WIDTH-1:0]      fetch_word_cnt,
  output logic                      imem_req,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic [FIFO_IFU_WIDTH-1:0] imem_rdata,
  input  logic                      imem_rvalid,
  input  logic                      idu2ifu_rd_rqst,
  output logic                      ifu2idu_fifo_empty,
  output logic [FIFO_IFU_WIDTH-1:0] ifu2idu_rd_data,
  output logic                      ifu2idu_rd_data_vld,
  output logic                      fetch_busy,
  output logic                      fetch_done,
  output logic                      fetch_err
);

  // Pointer width and occupancy/credit counter width (must reach DEPTH).
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [CNT_WIDTH-1:0]      remain_q;
  logic [CW-1:0]             outstanding_q;
  logic [CW-1:0]             outstanding_d;
  logic [CW-1:0]             fifo_count_q;
  logic [CW-1:0]             fifo_count_d;
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             rd_ptr_q;
  logic [FIFO_IFU_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_IFU_WIDTH-1:0] rd_data_q;
  logic                      rd_vld_q;

  logic [CW:0]               credit_sum_s;
  logic                      issue_s;
  logic                      push_s;
  logic                      pop_s;

  // A request may only be issued while every in-flight word still has a
  // guaranteed FIFO slot; pops in the same cycle are deliberately ignored.
  assign credit_sum_s = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
  assign issue_s      = (state_q == S_FETCH) && (credit_sum_s < DEPTH_L);

  // Responses are only accepted against an outstanding request; this also
  // discards anything still in flight from before a reset.
  assign push_s = imem_rvalid && (outstanding_q != '0);
  assign pop_s  = idu2ifu_rd_rqst && (fifo_count_q != '0);

  assign imem_req            = issue_s;
  assign imem_addr           = issue_s ? addr_q : '0;
  assign ifu2idu_fifo_empty  = (fifo_count_q == '0);
  assign ifu2idu_rd_data     = rd_data_q;
  assign ifu2idu_rd_data_vld = rd_vld_q;
  assign fetch_busy          = (state_q != S_IDLE);
  assign fetch_done          = (state_q == S_DONE);

  // Fetch sequencer: program latch, address/count stepping and state walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            if (fetch_word_cnt != '0) begin
              state_q  <= S_FETCH;
              addr_q   <= fetch_base_addr;
              remain_q <= fetch_word_cnt;
            end else begin
              state_q  <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (issue_s) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            remain_q <= remain_q - CNT_WIDTH'(1);
            if (remain_q == CNT_WIDTH'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (outstanding_q == '0) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Next value of the in-flight request counter (issue adds, response retires).
  always_comb begin
    outstanding_d = outstanding_q;
    case ({issue_s, push_s})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    fifo_count_d = fifo_count_q;
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and outstanding-request count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      outstanding_q <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // IDU read port: registered data with one-cycle latency, held when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      if (pop_s) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_vld_q  <= 1'b1;
      end else begin
        rd_vld_q  <= 1'b0;
      end
    end
  end

`ifdef IFU_FETCH_ERR_CHK_EN
  logic err_q;
  logic err_arm_q;

  // Sticky protocol-error flag. Spurious-response detection is armed only
  // once a program has been started after reset, so words still in flight
  // from before a reset are dropped without being reported.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q     <= 1'b0;
      err_arm_q <= 1'b0;
    end else begin
      if (fetch_start && (state_q == S_IDLE)) begin
        err_arm_q <= 1'b1;
      end
      if ((imem_rvalid && (outstanding_q == '0) && err_arm_q) ||
          (fetch_start && (state_q != S_IDLE))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Directed testbench for ifu_fetch_buffer with a fixed-latency (2 cycle)
// instruction memory model whose data word encodes its address.

module tb_ifu_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_start = 1'b0;
  logic [15:0] fetch_base_addr = 16'h0000;
  logic [15:0] fetch_word_cnt = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        imem_rvalid;
  logic        idu2ifu_rd_rqst = 1'b0;
  logic        ifu2idu_fifo_empty;
  logic [63:0] ifu2idu_rd_data;
  logic        ifu2idu_rd_data_vld;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int done_cnt = 0;

  logic        s1_vld = 1'b0;
  logic        s2_vld = 1'b0;
  logic [15:0] s1_addr = 16'h0000;
  logic [15:0] s2_addr = 16'h0000;
  logic        spur_vld = 1'b0;
  logic [63:0] spur_data = 64'h0;

  ifu_fetch_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_start         (fetch_start),
    .fetch_base_addr     (fetch_base_addr),
    .fetch_word_cnt      (fetch_word_cnt),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .imem_rvalid         (imem_rvalid),
    .idu2ifu_rd_rqst     (idu2ifu_rd_rqst),
    .ifu2idu_fifo_empty  (ifu2idu_fifo_empty),
    .ifu2idu_rd_data     (ifu2idu_rd_data),
    .ifu2idu_rd_data_vld (ifu2idu_rd_data_vld),
    .fetch_busy          (fetch_busy),
    .fetch_done          (fetch_done),
    .fetch_err           (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory model: fixed 2-cycle latency, data = DEADBEEF_0000_<addr>.
  always @(posedge clk) begin
    s1_vld  <= imem_req;
    s1_addr <= imem_addr;
    s2_vld  <= s1_vld;
    s2_addr <= s1_addr;
  end
  assign imem_rvalid = s2_vld | spur_vld;
  assign imem_rdata  = s2_vld ? {32'hDEADBEEF, 16'h0000, s2_addr} : spur_data;

  // Event counters for issued requests and done pulses.
  always @(posedge clk) begin
    if (imem_req)   req_cnt  <= req_cnt + 1;
    if (fetch_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] base, input logic [15:0] cnt);
    fetch_start     = 1'b1;
    fetch_base_addr = base;
    fetch_word_cnt  = cnt;
    tick();
    fetch_start     = 1'b0;
  endtask

  // Pop words for up to 'cycles' cycles, checking each against base+k.
  task automatic collect(input string tag, input logic [15:0] base, input int n, input int cycles);
    int k;
    logic [15:0] a;
    k = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ifu2idu_rd_data_vld) begin
        a = base + k[15:0];
        chk(tag, ifu2idu_rd_data, {32'hDEADBEEF, 16'h0000, a});
        k++;
      end
    end
    chk({tag, "_count"}, 64'(k), 64'(n));
  endtask

  initial begin
    int d0;
    int r0;

    // Reset values
    tick();
    tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_empty", ifu2idu_fifo_empty, 1'b1);
    chk("rst_data", ifu2idu_rd_data, 64'h0);
    chk("rst_vld", ifu2idu_rd_data_vld, 1'b0);
    chk("rst_busy", fetch_busy, 1'b0);
    chk("rst_done", fetch_done, 1'b0);
    chk("rst_err", fetch_err, 1'b0);
    rst = 1'b1;
    tick();

    // Basic program: base 0x10, count 3, IDU reading continuously
    d0 = done_cnt;
    idu2ifu_rd_rqst = 1'b1;
    start(16'h0010, 16'h0003);
    chk("t1_req0", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 16'h0010);
    chk("t1_busy", fetch_busy, 1'b1);
    tick();
    chk("t1_addr1", imem_addr, 16'h0011);
    tick();
    chk("t1_addr2", imem_addr, 16'h0012);
    tick();
    chk("t1_req_off", imem_req, 1'b0);
    chk("t1_empty_after_push", ifu2idu_fifo_empty, 1'b0);
    collect("t1_word", 16'h0010, 3, 12);
    chk("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t1_busy_end", fetch_busy, 1'b0);
    idu2ifu_rd_rqst = 1'b0;

    // Zero-count program: done without memory traffic
    d0 = done_cnt;
    r0 = req_cnt;
    start(16'h0055, 16'h0000);
    chk("t3_done", fetch_done, 1'b1);
    chk("t3_req", imem_req, 1'b0);
    tick();
    chk("t3_done_clr", fetch_done, 1'b0);
    chk("t3_busy", fetch_busy, 1'b0);
    chk("t3_no_req", 64'(req_cnt - r0), 64'd0);
    chk("t3_pulses", 64'(done_cnt - d0), 64'd1);

    // Address wrap
    idu2ifu_rd_rqst = 1'b1;
    start(16'hFFFE, 16'h0003);
    chk("t4_addr0", imem_addr, 16'hFFFE);
    tick();
    chk("t4_addr1", imem_addr, 16'hFFFF);
    tick();
    chk("t4_addr2", imem_addr, 16'h0000);
    chk("t4_req2", imem_req, 1'b1);
    tick();
    chk("t4_req_off", imem_req, 1'b0);
    collect("t4_word", 16'hFFFE, 3, 12);
    idu2ifu_rd_rqst = 1'b0;

    // Credit limit: 20 words into a 16-deep FIFO with the IDU idle
    d0 = done_cnt;
    r0 = req_cnt;
    start(16'h0100, 16'd20);
    repeat (40) tick();
    chk("t2_req_16", 64'(req_cnt - r0), 64'd16);
    chk("t2_req_stall", imem_req, 1'b0);
    chk("t2_not_empty", ifu2idu_fifo_empty, 1'b0);
    idu2ifu_rd_rqst = 1'b1;
    tick();
    chk("t2_pop0", ifu2idu_rd_data, 64'hDEADBEEF_0000_0100);
    tick();
    chk("t2_pop1", ifu2idu_rd_data, 64'hDEADBEEF_0000_0101);
    tick();
    chk("t2_pop2", ifu2idu_rd_data, 64'hDEADBEEF_0000_0102);
    tick();
    chk("t2_pop3", ifu2idu_rd_data, 64'hDEADBEEF_0000_0103);
    chk("t2_pop3_vld", ifu2idu_rd_data_vld, 1'b1);
    idu2ifu_rd_rqst = 1'b0;
    repeat (20) tick();
    chk("t2_req_20", 64'(req_cnt - r0), 64'd20);
    chk("t2_req_end", imem_req, 1'b0);
    idu2ifu_rd_rqst = 1'b1;
    collect("t2_word", 16'h0104, 16, 30);
    chk("t2_empty_end", ifu2idu_fifo_empty, 1'b1);
    chk("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    idu2ifu_rd_rqst = 1'b0;

    // Simultaneous push and pop with one word held, then read of empty FIFO
    start(16'h0200, 16'h0002);
    tick();
    tick();
    tick();
    chk("t5_one_word", ifu2idu_fifo_empty, 1'b0);
    idu2ifu_rd_rqst = 1'b1;
    tick();
    chk("t5_pp_vld", ifu2idu_rd_data_vld, 1'b1);
    chk("t5_pp_data", ifu2idu_rd_data, 64'hDEADBEEF_0000_0200);
    chk("t5_pp_empty", ifu2idu_fifo_empty, 1'b0);
    idu2ifu_rd_rqst = 1'b0;
    tick();
    chk("t5_idle_vld", ifu2idu_rd_data_vld, 1'b0);
    chk("t5_hold_data", ifu2idu_rd_data, 64'hDEADBEEF_0000_0200);
    idu2ifu_rd_rqst = 1'b1;
    tick();
    chk("t5_pop2", ifu2idu_rd_data, 64'hDEADBEEF_0000_0201);
    tick();
    chk("t5_empty_rd_vld", ifu2idu_rd_data_vld, 1'b0);
    chk("t5_empty_rd_data", ifu2idu_rd_data, 64'hDEADBEEF_0000_0201);
    chk("t5_empty", ifu2idu_fifo_empty, 1'b1);
    idu2ifu_rd_rqst = 1'b0;

    // Wait for IDLE (bounded)
    for (int i = 0; i < 20 && fetch_busy; i++) tick();
    chk("t6_idle_wait", fetch_busy, 1'b0);

    // Spurious memory response in IDLE
    spur_vld  = 1'b1;
    spur_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    spur_vld  = 1'b0;
`ifdef IFU_FETCH_ERR_CHK_EN
    chk("t6_err", fetch_err, 1'b1);
`else
    chk("t6_err", fetch_err, 1'b0);
`endif
    tick();
    chk("t6_spur_dropped", ifu2idu_fifo_empty, 1'b1);

    // Reset asserted during DRAIN
    start(16'h0400, 16'h0002);
    tick();
    tick();
    chk("t7_drain_busy", fetch_busy, 1'b1);
    chk("t7_drain_req", imem_req, 1'b0);
    rst = 1'b0;
    tick();
    chk("t7_req", imem_req, 1'b0);
    chk("t7_addr", imem_addr, 16'h0000);
    chk("t7_empty", ifu2idu_fifo_empty, 1'b1);
    chk("t7_data", ifu2idu_rd_data, 64'h0);
    chk("t7_vld", ifu2idu_rd_data_vld, 1'b0);
    chk("t7_busy", fetch_busy, 1'b0);
    chk("t7_done", fetch_done, 1'b0);
    chk("t7_err", fetch_err, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    chk("t7_late_rsp_dropped", ifu2idu_fifo_empty, 1'b1);
    chk("t7_late_rsp_no_err", fetch_err, 1'b0);

    // Pointers consistent after reset: next program delivers exactly its word
    idu2ifu_rd_rqst = 1'b1;
    start(16'h0300, 16'h0001);
    collect("t8_word", 16'h0300, 1, 10);
    chk("t8_empty", ifu2idu_fifo_empty, 1'b1);
    idu2ifu_rd_rqst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
